// File: rtl/mips_regfile_dbg.sv
// Parametrised MIPS register file: N combinational read ports, optional write bypass,
// and a valid/ready dump engine that streams every register out in index order.
module mips_regfile_dbg #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     dump_req,
  output logic                     dump_valid,
  input  logic                     dump_ready,
  output logic [ADDR_W-1:0]        dump_addr,
  output logic [DATA_W-1:0]        dump_data,
  output logic                     dump_busy,
  output logic                     dump_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   REG_LIMIT = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_ok;
  state_t            state, state_nxt;
  logic              load_beat;
  logic [ADDR_W-1:0] beat_addr;
  logic [DATA_W-1:0] beat_data;

  assign wr_ok = we && ({1'b0, wr_addr} < REG_LIMIT) && !(ZERO_REG && wr_addr == '0);

  // NOTE: the array is cleared on reset because software expects every register to read 0
  // after reset; this is why it cannot be mapped onto a plain RAM macro.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Shared by every read port and by the dump engine so a beat sees exactly what a port would.
  function automatic logic [DATA_W-1:0] lookup(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = '0;
    if (({1'b0, a} < REG_LIMIT) && !(ZERO_REG && a == '0)) begin
      if (BYPASS && wr_ok && wr_addr == a) v = wr_data;
      else                                 v = regs[a];
    end
    return v;
  endfunction

  always_comb begin
    rd_data = '0;
    for (int p = 0; p < NUM_RD; p++)
      rd_data[p*DATA_W +: DATA_W] = lookup(rd_addr[p*ADDR_W +: ADDR_W]);
  end

  assign beat_data = lookup(beat_addr);

  // NOTE: registered state is updated with <= so every flop samples pre-edge values;
  // blocking = is kept for combinational blocks only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt  = state;
    load_beat  = 1'b0;
    beat_addr  = '0;
    dump_valid = 1'b0;
    dump_done  = 1'b0;
    case (state)
      IDLE: begin
        if (dump_req) begin
          state_nxt = SEND;
          load_beat = 1'b1;
        end
      end
      SEND: begin
        dump_valid = 1'b1;
        if (dump_ready) begin
          if (dump_addr == LAST_IDX) begin
            state_nxt = DONE;
          end else begin
            load_beat = 1'b1;
            beat_addr = dump_addr + ADDR_W'(1);
          end
        end
      end
      DONE: begin
        dump_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign dump_busy = (state != IDLE);

  // The beat only reloads on acceptance, so a stalled beat holds even if its register changes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dump_addr <= '0;
      dump_data <= '0;
    end else if (load_beat) begin
      dump_addr <= beat_addr;
      dump_data <= beat_data;
    end
  end

endmodule

// File: tb/tb_mips_regfile_dbg.sv
// Directed bench for mips_regfile_dbg: a default 32x32 bypassing instance and a 24-entry
// non-bypassing instance without a hardwired zero register.
module tb_mips_regfile_dbg;

  logic        clk = 1'b0;
  logic        reset;

  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic        we;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        dump_req, dump_valid, dump_ready;
  logic [4:0]  dump_addr;
  logic [31:0] dump_data;
  logic        dump_busy, dump_done;

  logic [14:0] s_rd_addr;
  logic [95:0] s_rd_data;
  logic        s_we;
  logic [4:0]  s_wr_addr;
  logic [31:0] s_wr_data;
  logic        s_dump_req, s_dump_valid, s_dump_ready;
  logic [4:0]  s_dump_addr;
  logic [31:0] s_dump_data;
  logic        s_dump_busy, s_dump_done;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] exp_dump [32];

  always #5 clk = ~clk;

  mips_regfile_dbg u_dut (
    .clk        (clk),
    .reset      (reset),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .we         (we),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .dump_req   (dump_req),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .dump_busy  (dump_busy),
    .dump_done  (dump_done)
  );

  mips_regfile_dbg #(
    .NUM_REGS (24),
    .NUM_RD   (3),
    .BYPASS   (1'b0),
    .ZERO_REG (1'b0)
  ) u_small (
    .clk        (clk),
    .reset      (reset),
    .rd_addr    (s_rd_addr),
    .rd_data    (s_rd_data),
    .we         (s_we),
    .wr_addr    (s_wr_addr),
    .wr_data    (s_wr_data),
    .dump_req   (s_dump_req),
    .dump_valid (s_dump_valid),
    .dump_ready (s_dump_ready),
    .dump_addr  (s_dump_addr),
    .dump_data  (s_dump_data),
    .dump_busy  (s_dump_busy),
    .dump_done  (s_dump_done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; returns at the next posedge+1 with the write committed.
  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic s_write(input logic [4:0] a, input logic [31:0] d);
    s_we = 1'b1; s_wr_addr = a; s_wr_data = d;
    @(posedge clk); #1;
    s_we = 1'b0;
  endtask

  task automatic wait_beat(input logic [4:0] a);
    int n;
    n = 0;
    while (!(dump_valid && dump_addr == a) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_beat", {dump_valid, dump_addr}, {1'b1, a});
  endtask

  // Entered at posedge+1 with the first beat already valid; consumes the whole dump.
  task automatic dump_run(input bit rand_ready, input bit stall_writes);
    int          beat, dones, cyc, stall_cnt;
    bit          stalled;
    logic [4:0]  s_addr;
    logic [31:0] s_data;
    beat = 0; dones = 0; cyc = 0; stall_cnt = 0; stalled = 1'b0;
    s_addr = '0; s_data = '0;
    while (dones == 0 && cyc < 400) begin
      we = 1'b0;
      dump_req = rand_ready && (beat == 5);
      if (rand_ready) begin
        dump_ready = 1'($urandom_range(0, 1));
      end else if (stall_writes && dump_valid && dump_addr == 5'd12 && stall_cnt < 2) begin
        dump_ready = 1'b0;
        we      = 1'b1;
        wr_addr = (stall_cnt == 0) ? 5'd12 : 5'd20;
        wr_data = (stall_cnt == 0) ? 32'h0000_1212 : 32'hCAFE_F00D;
        stall_cnt++;
      end else begin
        dump_ready = 1'b1;
      end
      @(negedge clk);
      if (stalled && dump_valid) begin
        check("stall_addr_stable", dump_addr, s_addr);
        check("stall_data_stable", dump_data, s_data);
      end
      if (dump_done) begin
        dones++;
        check("done_after_last_beat", beat, 32);
        check("done_without_valid", dump_valid, 1'b0);
      end
      stalled = 1'b0;
      if (dump_valid) begin
        if (dump_ready) begin
          check("beat_addr", dump_addr, beat[4:0]);
          check("beat_data", dump_data, exp_dump[beat[4:0]]);
          beat++;
        end else begin
          stalled = 1'b1;
          s_addr  = dump_addr;
          s_data  = dump_data;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    we = 1'b0;
    dump_req = 1'b0;
    check("dump_done_count", dones, 1);
    check("dump_beat_count", beat, 32);
    check("done_one_cycle", dump_done, 1'b0);
    check("idle_after_dump", dump_busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    reset = 1'b1;
    rd_addr = '0; we = 1'b0; wr_addr = '0; wr_data = '0;
    dump_req = 1'b0; dump_ready = 1'b0;
    s_rd_addr = '0; s_we = 1'b0; s_wr_addr = '0; s_wr_data = '0;
    s_dump_req = 1'b0; s_dump_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Asynchronous reset while a beat with non-zero data is stalled
    write_reg(5'd3, 32'h55);
    rd_addr = {5'd0, 5'd3}; #1;
    check("pre_reset_read", rd_data[31:0], 32'h55);
    dump_req = 1'b1; dump_ready = 1'b1;
    @(posedge clk); #1;
    dump_req = 1'b0;
    check("req_to_valid", dump_valid, 1'b1);
    check("first_beat_addr", dump_addr, 5'd0);
    wait_beat(5'd3);
    dump_ready = 1'b0;
    @(posedge clk); #1;
    check("stalled_beat3_data", dump_data, 32'h55);
    #2 reset = 1'b1;
    #1;
    check("rst_rd_data", rd_data, 64'h0);
    check("rst_dump_valid", dump_valid, 1'b0);
    check("rst_dump_busy", dump_busy, 1'b0);
    check("rst_dump_done", dump_done, 1'b0);
    check("rst_dump_addr", dump_addr, 5'd0);
    check("rst_dump_data", dump_data, 32'h0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    rd_addr = {5'd31, 5'd3}; #1;
    check("post_reset_reads", rd_data, 64'h0);

    // Write then read on both ports
    write_reg(5'd5, 32'hDEAD_BEEF);
    rd_addr = {5'd5, 5'd5}; #1;
    check("rd_port0", rd_data[31:0], 32'hDEAD_BEEF);
    check("rd_port1", rd_data[63:32], 32'hDEAD_BEEF);

    // Hardwired zero register, including no bypass to it
    write_reg(5'd0, 32'h1234);
    rd_addr = {5'd0, 5'd0}; #1;
    check("zero_reg_read", rd_data[31:0], 32'h0);
    we = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF; #1;
    check("zero_reg_no_bypass", rd_data[63:32], 32'h0);
    @(posedge clk); #1;
    we = 1'b0;

    // Same-cycle bypass; the other port keeps its own address
    rd_addr = {5'd5, 5'd7};
    we = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5_A5A5; #1;
    check("bypass_port0", rd_data[31:0], 32'hA5A5_A5A5);
    check("bypass_other_port", rd_data[63:32], 32'hDEAD_BEEF);
    @(posedge clk); #1;
    we = 1'b0;
    check("bypass_committed", rd_data[31:0], 32'hA5A5_A5A5);

    // 24-entry instance: range limits, writable reg 0, no bypass
    s_write(5'd0, 32'h77);
    s_write(5'd23, 32'h2323);
    s_write(5'd30, 32'hBAD0_0030);
    s_write(5'd24, 32'hBAD0_0024);
    s_rd_addr = {5'd23, 5'd24, 5'd30}; #1;
    check("small_addr30", s_rd_data[31:0], 32'h0);
    check("small_addr24", s_rd_data[63:32], 32'h0);
    check("small_last_reg", s_rd_data[95:64], 32'h2323);
    s_rd_addr = {5'd0, 5'd0, 5'd0}; #1;
    check("small_reg0_writable", s_rd_data[31:0], 32'h77);
    check("small_reg0_port2", s_rd_data[95:64], 32'h77);
    s_rd_addr = {5'd0, 5'd0, 5'd7};
    s_we = 1'b1; s_wr_addr = 5'd7; s_wr_data = 32'hA5A5_A5A5; #1;
    check("small_no_bypass", s_rd_data[31:0], 32'h0);
    @(posedge clk); #1;
    s_we = 1'b0;
    check("small_after_edge", s_rd_data[31:0], 32'hA5A5_A5A5);

    // Full dump with random backpressure and dump_req pulsed during SEND
    for (int i = 0; i < 32; i++) begin
      write_reg(5'(i), 32'(i * 3));
      exp_dump[i] = 32'(i * 3);
    end
    dump_req = 1'b1; dump_ready = 1'b0;
    @(posedge clk); #1;
    dump_req = 1'b0;
    check("dump1_valid", dump_valid, 1'b1);
    dump_run(1'b1, 1'b0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | dump_busy | dump_done;
    end
    check("no_restart_after_dump", seen, 1'b0);

    // Reset at beat 10 aborts without a done pulse
    @(posedge clk); #1;
    dump_req = 1'b1; dump_ready = 1'b1;
    @(posedge clk); #1;
    dump_req = 1'b0;
    wait_beat(5'd10);
    #2 reset = 1'b1;
    #1;
    check("abort_busy", dump_busy, 1'b0);
    check("abort_valid", dump_valid, 1'b0);
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      seen = seen | dump_done;
    end
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | dump_done;
    end
    check("abort_no_done", seen, 1'b0);

    // Fresh dump of a cleared file, with writes to 12 and 20 while beat 12 stalls
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) exp_dump[i] = 32'h0;
    exp_dump[20] = 32'hCAFE_F00D;
    dump_req = 1'b1; dump_ready = 1'b0;
    @(posedge clk); #1;
    dump_req = 1'b0;
    dump_run(1'b0, 1'b1);
    rd_addr = {5'd20, 5'd12}; #1;
    check("reg12_after_dump", rd_data[31:0], 32'h0000_1212);
    check("reg20_after_dump", rd_data[63:32], 32'hCAFE_F00D);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mips_regfile_dbg.md
Name: mips_regfile_dbg

Overview:
Parametrised multi-read-port register file for the MIPS datapath. It generalises the fixed 32x32 register array with configurable width, depth and read-port count, plus optional write-to-read bypass. It adds a handshaked debug dump engine that streams every register out serially, so the verification environment can check architectural state without hierarchical peeking.

Parameters:
DATA_W, 32, register width in bits
NUM_REGS, 32, number of registers (2..256, need not be a power of two)
ADDR_W, $clog2(NUM_REGS), register index width (derived)
NUM_RD, 2, number of combinational read ports (1..4)
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports
ZERO_REG, 1, 1 = register 0 hardwired to zero

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous reset, active-high
rd_addr  input  NUM_RD*ADDR_W  packed read addresses, port i at [i*ADDR_W +: ADDR_W]
rd_data  output  NUM_RD*DATA_W  packed read data, port i at [i*DATA_W +: DATA_W]
we  input  1  write enable
wr_addr  input  ADDR_W  write address
wr_data  input  DATA_W  write data
dump_req  input  1  start dump, sampled in IDLE only
dump_valid  output  1  dump beat valid
dump_ready  input  1  consumer accepts beat
dump_addr  output  ADDR_W  index of current beat
dump_data  output  DATA_W  value of current beat
dump_busy  output  1  high while not IDLE
dump_done  output  1  one-cycle pulse after last beat

Behaviour:
- One clock, clk. reset is asynchronous and active-high.
- Reset, on assertion: all registers are 0 and the FSM goes to IDLE. dump_valid, dump_busy, dump_done, dump_addr and dump_data are all 0.
- Write: on a rising edge with we=1, regs[wr_addr] <= wr_data. The write is ignored if ZERO_REG=1 and wr_addr=0, or if wr_addr >= NUM_REGS.
- Read: combinational, zero latency.
  - rd_data[i] = regs[rd_addr[i]].
  - Returns 0 if the address is >= NUM_REGS.
  - Returns 0 if ZERO_REG=1 and the address is 0.
- Bypass (BYPASS=1): if we=1, wr_addr=rd_addr[i] and the write is not ignored, rd_data[i]=wr_data in the same cycle.
- BYPASS=0: reads return the pre-edge stored value.
- All read ports are independent. Identical addresses on several ports are legal.
- Dump FSM states: IDLE, SEND, DONE.
  - IDLE: if dump_req=1, go to SEND with idx=0 and load the beat.
  - SEND: dump_valid=1. A beat transfers when dump_valid & dump_ready.
    - On transfer with idx < NUM_REGS-1: idx++ and load the next beat (back-to-back beats allowed, one per cycle).
    - On transfer with idx = NUM_REGS-1: go to DONE.
  - DONE: dump_done=1 for exactly one cycle, dump_valid=0, then IDLE.
  - A new dump_req can start a dump on the cycle after DONE.
- Beat load: dump_addr <= idx. dump_data <= the value a read port would return for idx in that cycle, bypass included.
- Beat stability: dump_addr and dump_data are registered and held stable while dump_valid & !dump_ready, even if that register is written meanwhile.
- dump_busy = (state != IDLE).
- dump_req is ignored in SEND and DONE.
- Normal reads and writes continue unaffected during a dump.
- Reset asserted mid-dump aborts immediately to IDLE with no dump_done pulse.
- A dump of NUM_REGS registers with dump_ready held at 1 takes NUM_REGS cycles of valid, plus 1 DONE cycle, plus the 1-cycle req-to-valid latency.

Test Plan:
- Reset check: assert reset asynchronously mid-cycle -> all rd_data=0 and all dump outputs=0 immediately; a read of any address after release returns 0.
- Write then read: write reg 5=32'hDEADBEEF, then read it on port 0 and port 1 the next cycle -> both ports 32'hDEADBEEF.
- Zero register and range: write reg 0=32'h1234 -> reads 0. With NUM_REGS=24, write addr 30 -> ignored, and reading addr 30 returns 0.
- Bypass: with BYPASS=1, we=1, wr_addr=7, wr_data=32'hA5A5A5A5, rd_addr0=7 in the same cycle -> rd_data0=32'hA5A5A5A5 that cycle. With BYPASS=0 -> the old value, 0.
- Dump with backpressure:
  - Preload reg i = i*3, pulse dump_req, toggle dump_ready randomly.
  - Required: 32 beats in order, addr 0..31, data i*3 (reg 0 = 0), data stable while stalled.
  - Required: a single dump_done pulse after beat 31; dump_req during SEND is ignored.
- Abort and write during dump: assert reset at beat 10 -> IDLE, no dump_done. A new dump sees all regs 0. A write to reg 20 while beat 12 is stalled -> beat 20 carries the new value.
